// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus reader: debounces each digit position and stores its BCD value per slot.
// Optional build macro SEG7_ACTIVE_LOW_EN inverts seg and dig_sel at the input register (common-anode boards).
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     valid,
    output logic                  upd,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    localparam logic [3:0]        CNT_MAX = 4'(STABLE_CNT);
    localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_sel;
    state_t              r_state;
    logic [6:0]          r_lat_seg;
    logic [DIGITS-1:0]   r_lat_sel;
    logic [3:0]          r_cnt;
    logic [4*DIGITS-1:0] r_bcd;
    logic [DIGITS-1:0]   r_valid;
    logic                r_upd;
    logic                r_err;

    state_t              w_state_nxt;
    logic [3:0]          w_cnt_nxt;
    logic [3:0]          w_cnt_inc;
    logic                w_latch;
    logic                w_commit;
    logic                w_onehot;
    logic                w_same;
    logic [3:0]          w_dec;
    logic [3:0]          w_old;
    logic                w_old_valid;

    // Input stage: every comparison below works on these registered copies only.
    // NOTE: sequential state is assigned with <= so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_sel <= '0;
        end else begin
`ifdef SEG7_ACTIVE_LOW_EN
            r_seg <= ~seg;
            r_sel <= ~dig_sel;
`else
            r_seg <= seg;
            r_sel <= dig_sel;
`endif
        end
    end

    assign w_onehot = (r_sel != '0) && ((r_sel & (r_sel - SEL_ONE)) == '0);
    assign w_same   = (r_sel == r_lat_sel) && (r_seg == r_lat_seg);
    assign w_cnt_inc = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + 4'd1;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!w_onehot) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_IDLE;
                end else if (!w_same) begin
                    w_latch   = 1'b1;
                    w_cnt_nxt = 4'd1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_MAX) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (!w_onehot) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_IDLE;
                end else if (!w_same) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = S_COUNT;
                end
            end
            default: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lat_seg <= '0;
            r_lat_sel <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_lat_seg <= r_seg;
                r_lat_sel <= r_sel;
            end
        end
    end

    // Segment pattern to BCD; anything outside the ten digit shapes, blank included, is 4'hF.
    always_comb begin
        w_dec = 4'hF;
        unique case (r_lat_seg)
            7'b0111111: w_dec = 4'd0;
            7'b0000110: w_dec = 4'd1;
            7'b1011011: w_dec = 4'd2;
            7'b1001111: w_dec = 4'd3;
            7'b1100110: w_dec = 4'd4;
            7'b1101101: w_dec = 4'd5;
            7'b1111101: w_dec = 4'd6;
            7'b0000111: w_dec = 4'd7;
            7'b1111111: w_dec = 4'd8;
            7'b1101111: w_dec = 4'd9;
            default:    w_dec = 4'hF;
        endcase
    end

    always_comb begin
        w_old       = '0;
        w_old_valid = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_lat_sel[k]) begin
                w_old       = r_bcd[4*k +: 4];
                w_old_valid = r_valid[k];
            end
        end
    end

    // NOTE: the per-slot store is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd   <= '0;
            r_valid <= '0;
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            r_err <= 1'b0;
            if (w_commit) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (r_lat_sel[k]) begin
                        r_bcd[4*k +: 4] <= w_dec;
                        r_valid[k]      <= 1'b1;
                    end
                end
                r_upd <= (w_dec != w_old) || !w_old_valid;
                r_err <= (w_dec == 4'hF);
            end
        end
    end

    assign bcd_out = r_bcd;
    assign valid   = r_valid;
    assign upd     = r_upd;
    assign err     = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes expected commit pulses, a monitor pops them on upd/err.
// Build with SEG7_ACTIVE_LOW_EN defined to drive the same scenarios with inverted lines.
module tb_seg7_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int STABLE_CNT = 3;

    logic                  clk;
    logic                  rst_n;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     dig_sel;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     valid;
    logic                  upd;
    logic                  err;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(STABLE_CNT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg),
        .dig_sel (dig_sel),
        .bcd_out (bcd_out),
        .valid   (valid),
        .upd     (upd),
        .err     (err)
    );

    typedef struct {
        int         slot;
        logic [3:0] val;
        logic       upd;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [6:0] seg_code [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic set_in(input logic [6:0] s, input logic [DIGITS-1:0] d);
`ifdef SEG7_ACTIVE_LOW_EN
        seg     = ~s;
        dig_sel = ~d;
`else
        seg     = s;
        dig_sel = d;
`endif
    endtask

    // Called on a falling edge; holds the inputs for n sampling edges and returns on a falling edge.
    task automatic drive(input logic [6:0] s, input logic [DIGITS-1:0] d, input int n);
        set_in(s, d);
        repeat (n) @(negedge clk);
    endtask

    // Commit seen on the falling edge after the edge that is 1 + STABLE_CNT edges after the change.
    task automatic expect_commit(input int slot, input logic [3:0] v, input logic u, input logic e);
        exp_t x;
        x.slot = slot;
        x.val  = v;
        x.upd  = u;
        x.err  = e;
        x.cyc  = cyc + 1 + STABLE_CNT;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n && (upd || err)) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", {30'd0, upd, err}, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check($sformatf("slot%0d_value", x.slot), bcd_out[4*x.slot +: 4], x.val);
                check($sformatf("slot%0d_valid", x.slot), valid[x.slot], 1'b1);
                check("upd_pulse", upd, x.upd);
                check("err_pulse", err, x.err);
                check("commit_cycle", x.cyc, cyc);
            end
        end
    end

    initial begin
        seg_code[0] = 7'b0111111; seg_code[1] = 7'b0000110;
        seg_code[2] = 7'b1011011; seg_code[3] = 7'b1001111;
        seg_code[4] = 7'b1100110; seg_code[5] = 7'b1101101;
        seg_code[6] = 7'b1111101; seg_code[7] = 7'b0000111;
        seg_code[8] = 7'b1111111; seg_code[9] = 7'b1101111;

        rst_n = 1'b0;
        set_in(seg_code[5], 4'b0001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_bcd", bcd_out, 16'h0000);
            check("reset_valid", valid, 4'h0);
            check("reset_upd_err", {upd, err}, 2'b00);
        end
        set_in(7'b0000000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(7'b0000000, 4'b0000, 3);

        expect_commit(0, 4'd5, 1'b1, 1'b0);
        drive(seg_code[5], 4'b0001, 10);
        check("basic_bcd0", bcd_out[3:0], 4'd5);
        check("basic_valid", valid, 4'b0001);
        drive(7'b0000000, 4'b0000, 2);

        for (int d = 0; d < DIGITS; d++) begin
            expect_commit(d, 4'(d + 1), 1'b1, 1'b0);
            drive(seg_code[d + 1], 4'(1 << d), 8);
        end
        check("scan_bcd", bcd_out, 16'h4321);
        check("scan_valid", valid, 4'hF);
        for (int d = 0; d < DIGITS; d++) drive(seg_code[d + 1], 4'(1 << d), 8);
        check("rescan_bcd", bcd_out, 16'h4321);

        for (int i = 0; i < 4; i++) drive(seg_code[(i % 2 == 0) ? 7 : 1], 4'b0010, 2);
        check("glitch_bcd1", bcd_out[7:4], 4'd2);
        expect_commit(1, 4'd7, 1'b1, 1'b0);
        drive(seg_code[7], 4'b0010, 6);
        check("glitch_then_hold_bcd1", bcd_out[7:4], 4'd7);

        expect_commit(2, 4'hF, 1'b1, 1'b1);
        drive(7'b0000000, 4'b0100, 5);
        check("invalid_bcd2", bcd_out[11:8], 4'hF);

        drive(seg_code[8], 4'b0011, 20);
        drive(seg_code[9], 4'b0000, 20);
        check("badsel_bcd", bcd_out, 16'h4F71);
        check("badsel_valid", valid, 4'hF);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
